// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: word size, bubble encoding and fetch-stage enums.
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic { RUN, HALT } fetch_state_e;

  typedef enum logic [1:0] { IFID_HOLD, IFID_BUBBLE, IFID_LOAD } ifid_ctrl_e;
endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port plus the IF/ID register outputs that feed decode.
interface if_fetch_stage_if;
  import rv_pkg::*;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] if_id_instr;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc_plus4;
  logic            if_id_valid;

  modport master (
    output imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid,
    input  imem_rdata
  );
  modport slave (
    input  imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold, insert a bubble, or load a freshly fetched word.
module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP
) (
  input  logic            clk,
  input  logic            reset,
  input  ifid_ctrl_e      ctrl,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);
  logic [XLEN-1:0] instr_q, instr_d, pc_q, pc_d, pc4_q, pc4_d;
  logic            valid_q, valid_d;

  // A bubble leaves the pc fields alone; only instr/valid mark it empty.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (ctrl)
      IFID_BUBBLE: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      IFID_LOAD: begin
        instr_d = instr_i;
        pc_d    = pc_i;
        pc4_d   = pc_i + 32'd4;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = valid_q;
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, fault trapping and IF/ID control.
module if_fetch_stage
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              IMEM_BYTES = 65536,
  parameter logic [XLEN-1:0] NOP_INSTR  = RV_NOP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall_if,
  input  logic                     flush_id,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_target,
  if_fetch_stage_if.master         bus,
  output logic                     fetch_fault,
  output logic [XLEN-1:0]          fault_addr,
  output logic [XLEN-1:0]          fetch_count
);
  localparam logic [XLEN-1:0] LAST_ADDR = XLEN'(IMEM_BYTES - 4);

  function automatic logic addr_bad(input logic [XLEN-1:0] a);
    return (a[1:0] != 2'b00) || (a > LAST_ADDR);
  endfunction

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, fault_addr_q, fault_addr_d, count_q, count_d;
  logic            fault_q, fault_d;
  ifid_ctrl_e      ifid_ctrl;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;
    ifid_ctrl    = IFID_BUBBLE;
    if (state_q == RUN) begin
      if (redirect_valid) begin
        // Redirect beats stall; the wrong-path word on the bus is dropped.
        if (!addr_bad(redirect_target)) begin
          pc_d = redirect_target;
        end else begin
          fault_d      = 1'b1;
          fault_addr_d = redirect_target;
          state_d      = HALT;
        end
      end else if (stall_if) begin
        ifid_ctrl = flush_id ? IFID_BUBBLE : IFID_HOLD;
      end else if (addr_bad(pc_q)) begin
        fault_d      = 1'b1;
        fault_addr_d = pc_q;
        state_d      = HALT;
      end else begin
        pc_d = pc_q + 32'd4;
        if (!flush_id) begin
          ifid_ctrl = IFID_LOAD;
          count_d   = count_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .ctrl       (ifid_ctrl),
    .instr_i    (bus.imem_rdata),
    .pc_i       (pc_q),
    .instr_o    (bus.if_id_instr),
    .pc_o       (bus.if_id_pc),
    .pc_plus4_o (bus.if_id_pc_plus4),
    .valid_o    (bus.if_id_valid)
  );

  assign bus.imem_addr = pc_q;
  assign fetch_fault   = fault_q;
  assign fault_addr    = fault_addr_q;
  assign fetch_count   = count_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage with a combinational memory model.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall_if, flush_id, redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_fault;
  logic [31:0] fault_addr, fetch_count;
  int          passed = 0, total = 0;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .stall_if(stall_if), .flush_id(flush_id),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .bus(bus.master), .fetch_fault(fetch_fault), .fault_addr(fault_addr),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign bus.imem_rdata = w(bus.imem_addr);

  typedef struct {
    logic        rst, stall, flush, rv;
    logic [31:0] tgt, imem, instr, pc, pp4;
    logic        v, f;
    logic [31:0] fa, cnt;
  } vec_t;

  vec_t tab[30];

  function automatic vec_t mk(input logic rst, stall, flush, rv, input logic [31:0] tgt,
                              input logic [31:0] imem, instr, pc, pp4, input logic v, f,
                              input logic [31:0] fa, cnt);
    vec_t r;
    r.rst = rst; r.stall = stall; r.flush = flush; r.rv = rv; r.tgt = tgt;
    r.imem = imem; r.instr = instr; r.pc = pc; r.pp4 = pp4; r.v = v; r.f = f;
    r.fa = fa; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, exp);
    total++;
    if (act !== exp) $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    else passed++;
  endtask

  task automatic apply_row(input int i);
    @(negedge clk);
    reset = tab[i].rst; stall_if = tab[i].stall; flush_id = tab[i].flush;
    redirect_valid = tab[i].rv; redirect_target = tab[i].tgt;
    @(posedge clk); #1;
    chk("imem_addr", i, bus.imem_addr, tab[i].imem);
    chk("instr", i, bus.if_id_instr, tab[i].instr);
    chk("if_id_pc", i, bus.if_id_pc, tab[i].pc);
    chk("pc_plus4", i, bus.if_id_pc_plus4, tab[i].pp4);
    chk("valid", i, 32'(bus.if_id_valid), 32'(tab[i].v));
    chk("fault", i, 32'(fetch_fault), 32'(tab[i].f));
    chk("fault_addr", i, fault_addr, tab[i].fa);
    chk("count", i, fetch_count, tab[i].cnt);
  endtask

  initial begin
    reset = 1'b1; stall_if = 0; flush_id = 0; redirect_valid = 0; redirect_target = '0;
    //           rst stl fl rv tgt            imem          instr          pc         pp4        v f fa           cnt
    tab[0]  = mk(1, 0, 0, 0, 0,             0,            NOP,           0,         0,         0,0,0,           0);
    tab[1]  = mk(0, 0, 0, 0, 0,             4,            w(0),          0,         4,         1,0,0,           1);
    tab[2]  = mk(0, 0, 0, 0, 0,             8,            w(4),          4,         8,         1,0,0,           2);
    tab[3]  = mk(0, 0, 0, 0, 0,             12,           w(8),          8,         12,        1,0,0,           3);
    tab[4]  = mk(0, 0, 0, 0, 0,             16,           w(12),         12,        16,        1,0,0,           4);
    tab[5]  = mk(1, 0, 0, 0, 0,             0,            NOP,           0,         0,         0,0,0,           0);
    tab[6]  = mk(0, 0, 0, 0, 0,             4,            w(0),          0,         4,         1,0,0,           1);
    tab[7]  = mk(0, 0, 0, 0, 0,             8,            w(4),          4,         8,         1,0,0,           2);
    tab[8]  = mk(0, 1, 0, 0, 0,             8,            w(4),          4,         8,         1,0,0,           2);
    tab[9]  = mk(0, 1, 0, 0, 0,             8,            w(4),          4,         8,         1,0,0,           2);
    tab[10] = mk(0, 1, 0, 0, 0,             8,            w(4),          4,         8,         1,0,0,           2);
    tab[11] = mk(0, 0, 0, 0, 0,             12,           w(8),          8,         12,        1,0,0,           3);
    tab[12] = mk(0, 1, 0, 1, 32'h40,        32'h40,       NOP,           8,         12,        0,0,0,           3);
    tab[13] = mk(0, 0, 0, 0, 0,             32'h44,       w(32'h40),     32'h40,    32'h44,    1,0,0,           4);
    tab[14] = mk(0, 1, 1, 0, 0,             32'h44,       NOP,           32'h40,    32'h44,    0,0,0,           4);
    tab[15] = mk(0, 0, 1, 0, 0,             32'h48,       NOP,           32'h40,    32'h44,    0,0,0,           4);
    tab[16] = mk(0, 0, 0, 0, 0,             32'h4C,       w(32'h48),     32'h48,    32'h4C,    1,0,0,           5);
    tab[17] = mk(0, 0, 0, 1, 32'h42,        32'h4C,       NOP,           32'h48,    32'h4C,    0,1,32'h42,      5);
    tab[18] = mk(1, 1, 0, 0, 0,             0,            NOP,           0,         0,         0,0,0,           0);
    tab[19] = mk(0, 0, 0, 0, 0,             4,            w(0),          0,         4,         1,0,0,           1);
    tab[20] = mk(0, 0, 0, 1, 32'hFFF8,      32'hFFF8,     NOP,           0,         4,         0,0,0,           1);
    tab[21] = mk(0, 0, 0, 0, 0,             32'hFFFC,     w(32'hFFF8),   32'hFFF8,  32'hFFFC,  1,0,0,           2);
    tab[22] = mk(0, 0, 0, 0, 0,             32'h10000,    w(32'hFFFC),   32'hFFFC,  32'h10000, 1,0,0,           3);
    tab[23] = mk(0, 0, 0, 0, 0,             32'h10000,    NOP,           32'hFFFC,  32'h10000, 0,1,32'h10000,   3);
    tab[24] = mk(0, 0, 0, 0, 0,             32'h10000,    NOP,           32'hFFFC,  32'h10000, 0,1,32'h10000,   3);
    tab[25] = mk(1, 1, 0, 1, 32'h42,        0,            NOP,           0,         0,         0,0,0,           0);
    tab[26] = mk(0, 1, 0, 0, 0,             0,            NOP,           0,         0,         0,0,0,           0);
    tab[27] = mk(0, 0, 0, 1, 32'hFFFF_FFFC, 0,            NOP,           0,         0,         0,1,32'hFFFF_FFFC,0);
    tab[28] = mk(1, 0, 0, 0, 0,             0,            NOP,           0,         0,         0,0,0,           0);
    tab[29] = mk(0, 1, 0, 1, 32'h1,         0,            NOP,           0,         0,         0,1,32'h1,       0);

    for (int i = 0; i <= 17; i++) apply_row(i);

    // HALT must ignore stall, flush and even legal redirects.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      reset = 0; stall_if = 1'($urandom); flush_id = 1'($urandom);
      redirect_valid = 1'($urandom); redirect_target = 32'h100;
      @(posedge clk); #1;
      chk("halt_imem", 100 + k, bus.imem_addr, 32'h4C);
      chk("halt_valid", 100 + k, 32'(bus.if_id_valid), 0);
      chk("halt_instr", 100 + k, bus.if_id_instr, NOP);
      chk("halt_count", 100 + k, fetch_count, 5);
      chk("halt_fault", 100 + k, 32'(fetch_fault), 1);
      chk("halt_faddr", 100 + k, fault_addr, 32'h42);
    end

    for (int i = 18; i < 30; i++) apply_row(i);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
